// File: rtl/seg_scan_display_pkg.sv
// Shared constants and the BCD-nibble to active-low segment table for the
// multiplexed 7-segment display driver.
package seg_scan_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned BCD_W      = NUM_DIGITS * NIB_W;
  localparam int unsigned SEG_W      = 8;

  // Active-low segment patterns ordered {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [SEG_W-1:0] SEG_0    = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1    = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2    = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3    = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4    = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5    = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6    = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7    = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8    = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9    = 8'h90;
  localparam logic [SEG_W-1:0] SEG_DASH = 8'hBF;
  localparam logic [SEG_W-1:0] SEG_OFF  = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  function automatic logic [SEG_W-1:0] digit_segments(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_display_seg7_decode.sv
// Combinational digit decoder: BCD nibble plus decimal point and blank
// request to active-low segments.
module seg7_decode
  import seg_scan_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  input  logic             dp,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  // A blank digit also suppresses its decimal point
  always_comb begin
    seg_c = SEG_OFF;
    if (!blank) begin
      seg_c = digit_segments(nibble);
      if (dp) seg_c[SEG_W-1] = 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with per-frame
// BCD snapshot, leading-zero blanking and an anti-ghosting gap per slot.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned GAP_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BCD_W-1:0]      bcd,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [BCD_W-1:0]      shadow;
  logic                  load_pend;
  logic                  tick_c;
  logic                  gap_c;
  logic [NUM_DIGITS-1:0] lz_c;
  logic [NIB_W-1:0]      nibble_c;
  logic                  blank_c;
  logic [SEG_W-1:0]      dec_seg_c;
  logic [NUM_DIGITS-1:0] an_nxt_c;
  logic [SEG_W-1:0]      seg_nxt_c;

  assign tick_c = (cnt == CNT_W'(SCAN_DIV - 1));
  assign gap_c  = (cnt < CNT_W'(GAP_CYC));

  // lz_c[k] is set when shadow digits 7..k are all zero; digit 0 never qualifies
  always_comb begin
    logic run;
    run  = 1'b1;
    lz_c = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run     = run & (shadow[NIB_W*k +: NIB_W] == '0);
      lz_c[k] = run;
    end
  end

  assign nibble_c = shadow[{idx, 2'b00} +: NIB_W];
  assign blank_c  = blank_lz & lz_c[idx];

  seg7_decode u_decode (
    .nibble (nibble_c),
    .dp     (dp_mask[idx]),
    .blank  (blank_c),
    .seg_c  (dec_seg_c)
  );

  always_comb begin
    an_nxt_c  = AN_OFF;
    seg_nxt_c = SEG_OFF;
    if (en && !gap_c) begin
      an_nxt_c  = ~(NUM_DIGITS'(1) << idx);
      seg_nxt_c = dec_seg_c;
    end
  end

  // Prescaler, digit index, frame snapshot and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      load_pend <= 1'b1;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
    end else begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) idx <= idx + IDX_W'(1);
      if (load_pend) begin
        shadow    <= bcd;
        load_pend <= 1'b0;
      end else if (tick_c && idx == IDX_W'(NUM_DIGITS - 1)) begin
        shadow <= bcd;
      end
      an  <= an_nxt_c;
      seg <= seg_nxt_c;
    end
  end

endmodule
